// File: rtl/page_walk_pkg.sv
// Shared types for the 80386 two-level page walker: walk states, entry bit positions, fault code.
// The write-back states exist only when PAGE_WALK_AD_UPDATE_EN is defined.
package page_walk_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PDE_REQ,
        PDE_WAIT,
        PTE_REQ,
        PTE_WAIT,
`ifdef PAGE_WALK_AD_UPDATE_EN
        PDE_UPD,
        PDE_UPD_WAIT,
        PTE_UPD,
        PTE_UPD_WAIT,
`endif
        RESP
    } walk_state_t;

    localparam int ENTRY_P = 0;
    localparam int ENTRY_W = 1;
    localparam int ENTRY_U = 2;
    localparam int ENTRY_A = 5;
    localparam int ENTRY_D = 6;

    // Matches the low three bits of the 80386 page-fault error code.
    typedef struct packed {
        logic us;
        logic wr;
        logic p;
    } fault_code_t;

    function automatic logic pte_needs_update(input logic [31:0] pte, input logic write);
        return !pte[ENTRY_A] || (write && !pte[ENTRY_D]);
    endfunction

    function automatic logic [31:0] pte_with_ad(input logic [31:0] pte, input logic write);
        logic [31:0] r;
        r = pte;
        r[ENTRY_A] = 1'b1;
        if (write) r[ENTRY_D] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/page_walk_check.sv
// Combinational presence and U/S, R/W protection check over a PDE/PTE pair.
module page_walk_check
    import page_walk_pkg::*;
(
    input  logic [31:0] pde,
    input  logic [31:0] pte,
    input  logic        req_write,
    input  logic        req_user,
    output logic        fault,
    output fault_code_t fault_code
);

    logic unused_entry_bits;
    assign unused_entry_bits = ^{pde[31:3], pte[31:3]};

    always_comb begin
        fault         = 1'b0;
        fault_code.us = req_user;
        fault_code.wr = req_write;
        fault_code.p  = 1'b1;
        if (!pde[ENTRY_P] || !pte[ENTRY_P]) begin
            fault        = 1'b1;
            fault_code.p = 1'b0;
        end else if (req_user && !(pde[ENTRY_U] && pte[ENTRY_U])) begin
            fault = 1'b1;
        end else if (req_user && req_write && !(pde[ENTRY_W] && pte[ENTRY_W])) begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/page_walk_unit.sv
// 80386 page-table walker: PDE/PTE reads over a single-outstanding memory port.
// Define PAGE_WALK_AD_UPDATE_EN to write back Accessed/Dirty bits after a good walk.
module page_walk_unit
    import page_walk_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        paging_enable,
    input  logic [19:0] pdbr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_linear_address,
    input  logic        req_write,
    input  logic        req_user,
    output logic        rsp_valid,
    output logic [31:0] rsp_physical_address,
    output logic        rsp_fault,
    output logic [2:0]  rsp_fault_code,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    walk_state_t state, state_next;

    logic [31:0] lin_q;
    logic [19:0] pdbr_q;
    logic        write_q;
    logic        user_q;
    logic [31:0] pde_q;
    logic [31:0] phys_q;
    logic        fault_q;
    logic [2:0]  code_q;

    logic        chk_fault;
    fault_code_t chk_code;
    logic [31:0] pde_address;
    logic [31:0] pte_address;

    assign pde_address = {pdbr_q, lin_q[31:22], 2'b00};
    assign pte_address = {pde_q[31:12], lin_q[21:12], 2'b00};

    // During PTE_WAIT the PTE is taken straight off the read data bus.
    page_walk_check u_check (
        .pde        (pde_q),
        .pte        (mem_rdata),
        .req_write  (write_q),
        .req_user   (user_q),
        .fault      (chk_fault),
        .fault_code (chk_code)
    );

`ifdef PAGE_WALK_AD_UPDATE_EN
    logic [31:0] pte_q;

    always_ff @(posedge clock) begin
        if (state == PTE_WAIT && mem_rsp_valid) pte_q <= mem_rdata;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        mem_req_valid = 1'b0;
        mem_address   = 32'h0;
        mem_write     = 1'b0;
        mem_wdata     = 32'h0;
        case (state)
            IDLE: if (req_valid) state_next = paging_enable ? PDE_REQ : RESP;
            PDE_REQ: begin
                mem_req_valid = 1'b1;
                mem_address   = pde_address;
                if (mem_req_ready) state_next = PDE_WAIT;
            end
            PDE_WAIT: if (mem_rsp_valid) state_next = mem_rdata[ENTRY_P] ? PTE_REQ : RESP;
            PTE_REQ: begin
                mem_req_valid = 1'b1;
                mem_address   = pte_address;
                if (mem_req_ready) state_next = PTE_WAIT;
            end
`ifdef PAGE_WALK_AD_UPDATE_EN
            PTE_WAIT: if (mem_rsp_valid) begin
                if (chk_fault)                               state_next = RESP;
                else if (!pde_q[ENTRY_A])                    state_next = PDE_UPD;
                else if (pte_needs_update(mem_rdata, write_q)) state_next = PTE_UPD;
                else                                         state_next = RESP;
            end
            PDE_UPD: begin
                mem_req_valid = 1'b1;
                mem_write     = 1'b1;
                mem_address   = pde_address;
                mem_wdata     = pde_q | (32'h1 << ENTRY_A);
                if (mem_req_ready) state_next = PDE_UPD_WAIT;
            end
            PDE_UPD_WAIT: if (mem_rsp_valid)
                state_next = pte_needs_update(pte_q, write_q) ? PTE_UPD : RESP;
            PTE_UPD: begin
                mem_req_valid = 1'b1;
                mem_write     = 1'b1;
                mem_address   = pte_address;
                mem_wdata     = pte_with_ad(pte_q, write_q);
                if (mem_req_ready) state_next = PTE_UPD_WAIT;
            end
            PTE_UPD_WAIT: if (mem_rsp_valid) state_next = RESP;
`else
            PTE_WAIT: if (mem_rsp_valid) state_next = RESP;
`endif
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && req_valid) begin
            lin_q   <= req_linear_address;
            pdbr_q  <= pdbr;
            write_q <= req_write;
            user_q  <= req_user;
        end
        if (state == PDE_WAIT && mem_rsp_valid) pde_q <= mem_rdata;
    end

    // The response is settled at the last read; write-backs never change it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phys_q  <= 32'h0;
            fault_q <= 1'b0;
            code_q  <= 3'b000;
        end else begin
            case (state)
                IDLE: if (req_valid && !paging_enable) begin
                    phys_q  <= req_linear_address;
                    fault_q <= 1'b0;
                    code_q  <= 3'b000;
                end
                PDE_WAIT: if (mem_rsp_valid && !mem_rdata[ENTRY_P]) begin
                    phys_q  <= 32'h0;
                    fault_q <= 1'b1;
                    code_q  <= {user_q, write_q, 1'b0};
                end
                PTE_WAIT: if (mem_rsp_valid) begin
                    phys_q  <= chk_fault ? 32'h0 : {mem_rdata[31:12], lin_q[11:0]};
                    fault_q <= chk_fault;
                    code_q  <= chk_code;
                end
                default: ;
            endcase
        end
    end

    assign req_ready            = (state == IDLE);
    assign rsp_valid            = (state == RESP);
    assign rsp_physical_address = phys_q;
    assign rsp_fault            = fault_q;
    assign rsp_fault_code       = code_q;

endmodule

// File: tb/tb_page_walk_unit.sv
// Directed bench for page_walk_unit with a zero-wait memory responder.
// Expectations for the A/D write-back path follow PAGE_WALK_AD_UPDATE_EN.
module tb_page_walk_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        paging_enable;
    logic [19:0] pdbr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_linear_address;
    logic        req_write;
    logic        req_user;
    logic        rsp_valid;
    logic [31:0] rsp_physical_address;
    logic        rsp_fault;
    logic [2:0]  rsp_fault_code;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] cur_pde_addr;
    logic [31:0] cur_pde;
    logic [31:0] cur_pte;
    int          pte_delay = 0;
    int          mem_count = 0;
    logic [31:0] log_addr [8];
    logic        log_wr   [8];
    logic [31:0] log_data [8];

    always #5 clock = ~clock;

    page_walk_unit dut (
        .clock                (clock),
        .reset                (reset),
        .paging_enable        (paging_enable),
        .pdbr                 (pdbr),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_linear_address   (req_linear_address),
        .req_write            (req_write),
        .req_user             (req_user),
        .rsp_valid            (rsp_valid),
        .rsp_physical_address (rsp_physical_address),
        .rsp_fault            (rsp_fault),
        .rsp_fault_code       (rsp_fault_code),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_address          (mem_address),
        .mem_write            (mem_write),
        .mem_wdata            (mem_wdata),
        .mem_rsp_valid        (mem_rsp_valid),
        .mem_rdata            (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: accepts at once, answers one cycle after the request.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        forever begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready) begin
                automatic logic [31:0] a = mem_address;
                automatic logic        w = mem_write;
                automatic int          extra = 0;
                if (mem_count < 8) begin
                    log_addr[mem_count] = a;
                    log_wr[mem_count]   = w;
                    log_data[mem_count] = mem_wdata;
                end
                mem_count++;
                if (!w && a != cur_pde_addr) extra = pte_delay;
                @(posedge clock);
                repeat (extra) @(posedge clock);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rdata     = w ? 32'h0 : ((a == cur_pde_addr) ? cur_pde : cur_pte);
                @(posedge clock);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rdata     = 32'h0;
            end
        end
    end

    task automatic do_walk(input logic pg, input logic [19:0] base, input logic [31:0] lin,
                           input logic wr, input logic usr,
                           input logic [31:0] pde_val, input logic [31:0] pte_val,
                           output int lat, output logic [31:0] phys,
                           output logic flt, output logic [2:0] code);
        cur_pde_addr = {base, lin[31:22], 2'b00};
        cur_pde      = pde_val;
        cur_pte      = pte_val;
        mem_count    = 0;
        lat  = 0;
        phys = 32'hx;
        flt  = 1'bx;
        code = 3'bx;
        @(negedge clock);
        paging_enable      = pg;
        pdbr               = base;
        req_linear_address = lin;
        req_write          = wr;
        req_user           = usr;
        req_valid          = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat  = k;
                phys = rsp_physical_address;
                flt  = rsp_fault;
                code = rsp_fault_code;
                break;
            end
        end
        if (lat == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL walk_timeout: got no rsp_valid, expected one within 40 cycles");
        end
    endtask

    int          lat;
    logic [31:0] phys;
    logic        flt;
    logic [2:0]  code;
    logic        saw_rsp;
    logic        saw_mem;

    initial begin
        reset              = 1'b1;
        paging_enable      = 1'b0;
        pdbr               = 20'h0;
        req_valid          = 1'b0;
        req_linear_address = 32'h0;
        req_write          = 1'b0;
        req_user           = 1'b0;
        mem_req_ready      = 1'b1;
        cur_pde_addr       = 32'hFFFF_FFFF;
        cur_pde            = 32'h0;
        cur_pte            = 32'h0;
        repeat (2) @(negedge clock);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_fault", 32'(rsp_fault), 32'h0);
        check_eq("rst_fault_code", 32'(rsp_fault_code), 32'h0);
        check_eq("rst_phys", rsp_physical_address, 32'h0);
        check_eq("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check_eq("rst_mem_write", 32'(mem_write), 32'h0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Paging disabled: identity mapping, no memory traffic.
        do_walk(1'b0, 20'h00010, 32'h00403ABC, 1'b0, 1'b1, 32'h0, 32'h0, lat, phys, flt, code);
        check_eq("off_latency", 32'(lat), 32'd1);
        check_eq("off_phys", phys, 32'h00403ABC);
        check_eq("off_fault", 32'(flt), 32'h0);
        check_eq("off_mem_cycles", 32'(mem_count), 32'd0);

        // Full user-read walk.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b0, 1'b1, 32'h00020067, 32'h12345067,
                lat, phys, flt, code);
        check_eq("walk_latency", 32'(lat), 32'd5);
        check_eq("walk_phys", phys, 32'h12345ABC);
        check_eq("walk_fault", 32'(flt), 32'h0);
        check_eq("walk_mem_cycles", 32'(mem_count), 32'd2);
        check_eq("walk_pde_addr", log_addr[0], 32'h00010004);
        check_eq("walk_pte_addr", log_addr[1], 32'h0002000C);
        check_eq("walk_pte_is_read", 32'(log_wr[1]), 32'h0);

        // PDE not present: no PTE read.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b0, 1'b1, 32'h00020066, 32'h12345067,
                lat, phys, flt, code);
        check_eq("pdenp_latency", 32'(lat), 32'd3);
        check_eq("pdenp_fault", 32'(flt), 32'h1);
        check_eq("pdenp_code", 32'(code), 32'h4);
        check_eq("pdenp_phys", phys, 32'h0);
        check_eq("pdenp_mem_cycles", 32'(mem_count), 32'd1);

        // User write to a read-only PTE.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b1, 1'b1, 32'h00020067, 32'h12345065,
                lat, phys, flt, code);
        check_eq("uwro_latency", 32'(lat), 32'd5);
        check_eq("uwro_fault", 32'(flt), 32'h1);
        check_eq("uwro_code", 32'(code), 32'h7);
        check_eq("uwro_phys", phys, 32'h0);

        // User read through a supervisor-only PDE.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b0, 1'b1, 32'h00020063, 32'h12345067,
                lat, phys, flt, code);
        check_eq("usup_fault", 32'(flt), 32'h1);
        check_eq("usup_code", 32'(code), 32'h5);

        // Supervisor write to a non-present PTE.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b1, 1'b0, 32'h00020067, 32'h12345066,
                lat, phys, flt, code);
        check_eq("ptenp_fault", 32'(flt), 32'h1);
        check_eq("ptenp_code", 32'(code), 32'h2);

        // Supervisor write to a read-only, supervisor page: never protection-faulted.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b1, 1'b0, 32'h00020061, 32'h12345061,
                lat, phys, flt, code);
        check_eq("swro_latency", 32'(lat), 32'd5);
        check_eq("swro_fault", 32'(flt), 32'h0);
        check_eq("swro_phys", phys, 32'h12345ABC);

        // A/D clear on both entries, supervisor write.
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b1, 1'b0, 32'h00020007, 32'h12345007,
                lat, phys, flt, code);
        check_eq("ad_phys", phys, 32'h12345ABC);
        check_eq("ad_fault", 32'(flt), 32'h0);
`ifdef PAGE_WALK_AD_UPDATE_EN
        check_eq("ad_latency", 32'(lat), 32'd9);
        check_eq("ad_mem_cycles", 32'(mem_count), 32'd4);
        check_eq("ad_pde_wr", 32'(log_wr[2]), 32'h1);
        check_eq("ad_pde_wr_addr", log_addr[2], 32'h00010004);
        check_eq("ad_pde_wr_data", log_data[2], 32'h00020027);
        check_eq("ad_pte_wr", 32'(log_wr[3]), 32'h1);
        check_eq("ad_pte_wr_addr", log_addr[3], 32'h0002000C);
        check_eq("ad_pte_wr_data", log_data[3], 32'h12345067);
`else
        check_eq("ad_latency", 32'(lat), 32'd5);
        check_eq("ad_mem_cycles", 32'(mem_count), 32'd2);
        check_eq("ad_no_write", 32'(log_wr[1]), 32'h0);
`endif

        // Two memory wait cycles on the PTE read add two cycles.
        pte_delay = 2;
        do_walk(1'b1, 20'h00010, 32'h00403ABC, 1'b0, 1'b1, 32'h00020067, 32'h12345067,
                lat, phys, flt, code);
        check_eq("wait_latency", 32'(lat), 32'd7);
        check_eq("wait_phys", phys, 32'h12345ABC);

        // Reset in PTE_WAIT; the delayed PTE response arrives after reset and must be ignored.
        pte_delay    = 3;
        cur_pde_addr = 32'h00010004;
        cur_pde      = 32'h00020067;
        cur_pte      = 32'h12345067;
        @(negedge clock);
        paging_enable      = 1'b1;
        pdbr               = 20'h00010;
        req_linear_address = 32'h00403ABC;
        req_write          = 1'b0;
        req_user           = 1'b1;
        req_valid          = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("mid_not_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        #1;
        check_eq("mid_async_ready", 32'(req_ready), 32'h1);
        @(negedge clock);
        reset   = 1'b0;
        saw_rsp = 1'b0;
        saw_mem = 1'b0;
        repeat (6) begin
            @(negedge clock);
            saw_rsp |= rsp_valid;
            saw_mem |= mem_req_valid;
        end
        check_eq("mid_no_rsp", 32'(saw_rsp), 32'h0);
        check_eq("mid_no_mem", 32'(saw_mem), 32'h0);
        check_eq("mid_req_ready", 32'(req_ready), 32'h1);
        pte_delay = 0;

        // Walker accepts again after the mid-walk reset.
        do_walk(1'b0, 20'h00010, 32'h00001234, 1'b0, 1'b0, 32'h0, 32'h0, lat, phys, flt, code);
        check_eq("post_latency", 32'(lat), 32'd1);
        check_eq("post_phys", phys, 32'h00001234);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
